// File: rtl/cmd_host_seq_if.sv
// ----------------------------------------------------------------------------
// cmd_host_seq_if
// Bundles the host request/status signals, the byte-level UART transceiver
// handshake and the dump buffer write port of cmd_host_seq.
//   host side : cmd, start -> ; <- busy, done, err, resp
//   uart side : <- tx_data, trmt ; tx_done -> ; rx_data, rx_rdy -> ; <- clr_rx_rdy
//   dump port : <- dump_we, dump_addr, dump_data
// modport slave  : the sequencer (cmd_host_seq)
// modport master : whatever drives the sequencer (host controller + transceiver)
// ----------------------------------------------------------------------------
interface cmd_host_seq_if #(
    parameter int LOG2 = 9
);
    logic [15:0]     cmd;
    logic            start;
    logic            busy;
    logic            done;
    logic            err;
    logic [7:0]      resp;
    logic [7:0]      tx_data;
    logic            trmt;
    logic            tx_done;
    logic [7:0]      rx_data;
    logic            rx_rdy;
    logic            clr_rx_rdy;
    logic            dump_we;
    logic [LOG2-1:0] dump_addr;
    logic [7:0]      dump_data;

    modport master (
        output cmd, start, tx_done, rx_data, rx_rdy,
        input  busy, done, err, resp, tx_data, trmt, clr_rx_rdy,
               dump_we, dump_addr, dump_data
    );

    modport slave (
        input  cmd, start, tx_done, rx_data, rx_rdy,
        output busy, done, err, resp, tx_data, trmt, clr_rx_rdy,
               dump_we, dump_addr, dump_data
    );
endinterface

// File: rtl/cmd_host_seq.sv
// ----------------------------------------------------------------------------
// cmd_host_seq
// Host-side initiator for the analyzer command protocol. A 16-bit command is
// sent as two UART bytes (high byte first); rd/wr commands then collect one
// reply byte, a dump collects ENTRIES bytes and streams them to a buffer.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous reset, active high
//   bus    cmd_host_seq_if.slave:
//          cmd[15:14] opcode (00 rd, 01 wr, 10 dump, 11 illegal), start,
//          busy, done (1-cycle), err (valid with done), resp (last reply),
//          tx_data/trmt/tx_done (transmit), rx_data/rx_rdy/clr_rx_rdy
//          (receive), dump_we/dump_addr/dump_data (dump buffer write port)
// ----------------------------------------------------------------------------
module cmd_host_seq #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9,
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_W    = 20
) (
    input  logic          i_clk,
    input  logic          i_rst,
    cmd_host_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX_HI   = 3'd1,
        S_WT_HI   = 3'd2,
        S_TX_LO   = 3'd3,
        S_WT_LO   = 3'd4,
        S_RX_RESP = 3'd5,
        S_RX_DUMP = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    localparam logic [1:0]      OP_WR    = 2'b01;
    localparam logic [1:0]      OP_DUMP  = 2'b10;
    localparam logic [1:0]      OP_ILL   = 2'b11;
    localparam logic [7:0]      BYTE_NAK = 8'hEE;
    localparam logic [7:0]      BYTE_ACK = 8'hA5;
    localparam logic [LOG2-1:0] LAST_IDX = LOG2'(ENTRIES - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t          r_state;
    logic [1:0]      r_op;
    logic [7:0]      r_lo;
    logic [LOG2-1:0] r_idx;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [7:0]      r_resp;
    logic [7:0]      r_tx_data;
    logic            r_trmt;
    logic            r_dump_we;
    logic [LOG2-1:0] r_dump_addr;
    logic [7:0]      r_dump_data;

    logic            w_reject;
    logic            w_clr_rx_rdy;
    logic            w_to_expired;

    // Local reject of a command: illegal opcode or dump with a code outside 1..5
    always_comb begin
        w_reject = 1'b0;
        case (bus.cmd[15:14])
            OP_ILL:  w_reject = 1'b1;
            OP_DUMP: w_reject = (bus.cmd[10:8] == 3'd0) || (bus.cmd[10:8] > 3'd5);
            default: w_reject = 1'b0;
        endcase
    end

    // Every busy state consumes (or discards) a pending rx byte in the same cycle
    always_comb begin
        w_clr_rx_rdy = 1'b0;
        case (r_state)
            S_IDLE, S_FIN: w_clr_rx_rdy = 1'b0;
            default:       w_clr_rx_rdy = bus.rx_rdy;
        endcase
    end

    assign w_to_expired = (r_to_cnt == TO_LAST);

    // Transfer sequencer: state, timeout counter and all registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_lo        <= 8'h00;
            r_idx       <= '0;
            r_to_cnt    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_resp      <= 8'h00;
            r_tx_data   <= 8'h00;
            r_trmt      <= 1'b0;
            r_dump_we   <= 1'b0;
            r_dump_addr <= '0;
            r_dump_data <= 8'h00;
        end else begin
            // strobes default low; states raise them for exactly one cycle
            r_trmt    <= 1'b0;
            r_done    <= 1'b0;
            r_dump_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.cmd[15:14];
                        r_lo     <= bus.cmd[7:0];
                        r_idx    <= '0;
                        r_to_cnt <= '0;
                        if (w_reject) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state   <= S_TX_HI;
                            r_busy    <= 1'b1;
                            r_err     <= 1'b0;
                            r_trmt    <= 1'b1;
                            r_tx_data <= bus.cmd[15:8];
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_TX_HI: begin
                    r_state  <= S_WT_HI;
                    r_to_cnt <= '0;
                end
                S_WT_HI: begin
                    if (bus.tx_done) begin
                        r_state   <= S_TX_LO;
                        r_trmt    <= 1'b1;
                        r_tx_data <= r_lo;
                        r_to_cnt  <= '0;
                    end else if (bus.rx_rdy) begin
                        r_to_cnt <= '0;
                    end else if (w_to_expired) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_TX_LO: begin
                    r_state  <= S_WT_LO;
                    r_to_cnt <= '0;
                end
                S_WT_LO: begin
                    if (bus.tx_done) begin
                        r_state  <= (r_op == OP_DUMP) ? S_RX_DUMP : S_RX_RESP;
                        r_to_cnt <= '0;
                    end else if (bus.rx_rdy) begin
                        r_to_cnt <= '0;
                    end else if (w_to_expired) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_RX_RESP: begin
                    if (bus.rx_rdy) begin
                        // a write must be acknowledged; NAK fails any command
                        r_resp  <= bus.rx_data;
                        r_err   <= (bus.rx_data == BYTE_NAK) ||
                                   ((r_op == OP_WR) && (bus.rx_data != BYTE_ACK));
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_to_expired) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_RX_DUMP: begin
                    if (bus.rx_rdy) begin
                        // dump bytes are raw data: no NAK interpretation
                        r_dump_we   <= 1'b1;
                        r_dump_addr <= r_idx;
                        r_dump_data <= bus.rx_data;
                        r_to_cnt    <= '0;
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + LOG2'(1);
                        end
                    end else if (w_to_expired) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.resp       = r_resp;
    assign bus.tx_data    = r_tx_data;
    assign bus.trmt       = r_trmt;
    assign bus.clr_rx_rdy = w_clr_rx_rdy;
    assign bus.dump_we    = r_dump_we;
    assign bus.dump_addr  = r_dump_addr;
    assign bus.dump_data  = r_dump_data;
endmodule

// File: tb/tb_cmd_host_seq.sv
// ----------------------------------------------------------------------------
// tb_cmd_host_seq
// Plays host and UART transceiver around cmd_host_seq. Expected results come
// from the protocol rules: which bytes go out, which reply is taken, when done
// must rise and what err/resp/dump contents must be.
// ----------------------------------------------------------------------------
module tb_cmd_host_seq;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
    localparam int TIMEOUT = 40;
    localparam int TO_W    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    cmd_host_seq_if #(.LOG2(LOG2)) bus();

    cmd_host_seq #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // observation logs (cumulative; the sequencer process snapshots sizes)
    logic [7:0]      tx_log[$];
    int              tx_cyc_log[$];
    logic [LOG2-1:0] dw_addr_log[$];
    logic [7:0]      dw_data_log[$];
    int              done_cnt  = 0;
    int              done_cyc  = 0;
    logic            done_err  = 1'b0;

    logic [7:0]      dump_src[ENTRIES];
    logic [7:0]      model_resp = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.trmt) begin
                tx_log.push_back(bus.tx_data);
                tx_cyc_log.push_back(cyc);
            end
            if (bus.dump_we) begin
                dw_addr_log.push_back(bus.dump_addr);
                dw_data_log.push_back(bus.dump_data);
            end
            if (bus.done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                done_err = bus.err;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_trmt(output int t);
        t = -1;
        for (int k = 0; k < 12; k++) begin
            if (bus.trmt) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq("trmt_seen", (t >= 0), 1);
    endtask

    // tx_done some cycles after the strobe (never in the strobe cycle itself)
    task automatic pulse_tx_done(output int t);
        @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.tx_done = 1'b1;
        t = cyc;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    // present one rx byte and hold it until the DUT clears it
    task automatic send_rx(input logic [7:0] b, output int t);
        t = -1;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.clr_rx_rdy) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        check_eq("rx_consumed", (t >= 0), 1);
        @(negedge clk);
        bus.rx_rdy = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},  bus.busy, 0);
        check_eq({tag, "_done"},  bus.done, 0);
        check_eq({tag, "_err"},   bus.err, 0);
        check_eq({tag, "_resp"},  bus.resp, 0);
        check_eq({tag, "_trmt"},  bus.trmt, 0);
        check_eq({tag, "_txd"},   bus.tx_data, 0);
        check_eq({tag, "_clr"},   bus.clr_rx_rdy, 0);
        check_eq({tag, "_we"},    bus.dump_we, 0);
        check_eq({tag, "_daddr"}, bus.dump_addr, 0);
        check_eq({tag, "_ddata"}, bus.dump_data, 0);
    endtask

    // one complete transfer; silent = transceiver never replies
    task automatic run_xfer(input logic [15:0] c, input logic [7:0] reply,
                            input bit silent, input bit noisy);
        logic [1:0] op;
        bit         reject;
        bit         exp_err;
        int         exp_done;
        int         t_start, t_tx, t_td, t_last;
        int         tx_base, dw_base, done_base, ntx, ndw, bad;

        op        = c[15:14];
        reject    = (op == 2'b11) || ((op == 2'b10) && ((c[10:8] == 3'd0) || (c[10:8] > 3'd5)));
        tx_base   = tx_log.size();
        dw_base   = dw_addr_log.size();
        done_base = done_cnt;
        exp_err   = 1'b0;
        exp_done  = 0;
        t_last    = 0;

        bus.cmd   = c;
        bus.start = 1'b1;
        t_start   = cyc;
        @(negedge clk);
        bus.start = 1'b0;

        if (reject) begin
            exp_err  = 1'b1;
            exp_done = t_start + 1;
        end else begin
            wait_trmt(t_tx);
            check_eq("start_to_trmt", t_tx - t_start, 1);
            check_eq("busy_on", bus.busy, 1);
            if (noisy) begin
                // a start while busy must be ignored
                @(negedge clk);
                bus.cmd   = 16'($urandom);
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end
            pulse_tx_done(t_td);
            wait_trmt(t_tx);
            if (noisy) send_rx(8'($urandom), t_last);   // stray byte, discarded
            pulse_tx_done(t_td);
            if (silent) begin
                // RX starts the cycle after tx_done is taken; TIMEOUT silent
                // cycles are tolerated there before the abort shows as done
                exp_err  = 1'b1;
                exp_done = t_td + 1 + TIMEOUT;
            end else if (op == 2'b10) begin
                for (int i = 0; i < ENTRIES; i++) send_rx(dump_src[i], t_last);
                exp_err  = 1'b0;
                exp_done = t_last + 1;
            end else begin
                send_rx(reply, t_last);
                exp_err    = (reply == 8'hEE) || ((op == 2'b01) && (reply != 8'hA5));
                exp_done   = t_last + 1;
                model_resp = reply;
            end
        end

        for (int k = 0; (k < TIMEOUT + 20) && (done_cnt == done_base); k++) begin
            @(negedge clk);
            #1;
        end
        repeat (2) @(negedge clk);
        #1;

        ntx = tx_log.size() - tx_base;
        ndw = dw_addr_log.size() - dw_base;
        check_eq("done_count", done_cnt - done_base, 1);
        check_eq("done_cycle", done_cyc, exp_done);
        check_eq("err", done_err, exp_err);
        check_eq("resp", bus.resp, model_resp);
        check_eq("busy_off", bus.busy, 0);
        check_eq("tx_count", ntx, reject ? 0 : 2);
        if (ntx == 2) begin
            check_eq("tx_hi", tx_log[tx_base], c[15:8]);
            check_eq("tx_lo", tx_log[tx_base + 1], c[7:0]);
        end
        if ((op == 2'b10) && !reject && !silent) begin
            check_eq("dump_count", ndw, ENTRIES);
            bad = 0;
            for (int i = 0; (i < ndw) && (i < ENTRIES); i++) begin
                if ((dw_addr_log[dw_base + i] !== LOG2'(i)) ||
                    (dw_data_log[dw_base + i] !== dump_src[i])) bad++;
            end
            check_eq("dump_content", bad, 0);
            if (ndw > 0) begin
                check_eq("dump_last_addr", dw_addr_log[dw_base + ndw - 1], ENTRIES - 1);
                check_eq("dump_last_data", dw_data_log[dw_base + ndw - 1], dump_src[ENTRIES - 1]);
            end
        end else begin
            check_eq("no_dump_we", ndw, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int         t, dw_base, done_base, n_dumps;
        logic [15:0] c;
        logic [7:0]  r;
        bit          sil, noisy;
        int          m;

        bus.cmd = 16'h0000; bus.start = 1'b0; bus.tx_done = 1'b0;
        bus.rx_data = 8'h00; bus.rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("after_reset");

        run_xfer(16'h4B0F, 8'hA5, 1'b0, 1'b0);
        run_xfer(16'h0B00, 8'h0F, 1'b0, 1'b0);
        run_xfer(16'h0B00, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < ENTRIES; i++) dump_src[i] = 8'(i & 8'hFF);
        run_xfer(16'h8100, 8'h00, 1'b0, 1'b0);
        run_xfer(16'h4B0F, 8'h00, 1'b1, 1'b0);
        run_xfer(16'hC000, 8'h00, 1'b0, 1'b0);
        run_xfer(16'h8600, 8'h00, 1'b0, 1'b0);

        // reset in the middle of a dump: no done, outputs cleared
        dw_base   = dw_addr_log.size();
        done_base = done_cnt;
        bus.cmd   = 16'h8100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_trmt(t);
        pulse_tx_done(t);
        wait_trmt(t);
        pulse_tx_done(t);
        for (int i = 0; i < 100; i++) send_rx(8'(i), t);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_dump_rst");
        check_eq("rst_partial_writes", dw_addr_log.size() - dw_base, 100);
        check_eq("rst_no_done", done_cnt - done_base, 0);
        model_resp = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_xfer(16'h4B0F, 8'hA5, 1'b0, 1'b0);

        n_dumps = 0;
        for (int n = 0; n < 24; n++) begin
            m     = $urandom_range(0, 9);
            c     = 16'($urandom);
            r     = 8'($urandom);
            sil   = 1'b0;
            noisy = ($urandom_range(0, 3) == 0);
            case (m)
                0, 1, 2: begin
                    c[15:14] = 2'b00;
                    if ($urandom_range(0, 3) == 0) r = 8'hEE;
                end
                3, 4, 5: begin
                    c[15:14] = 2'b01;
                    if ($urandom_range(0, 1) == 0) r = 8'hA5;
                    else if ($urandom_range(0, 2) == 0) r = 8'hEE;
                end
                6: c[15:14] = 2'b11;
                7: begin
                    c[15:14] = 2'b10;
                    case ($urandom_range(0, 2))
                        0:       c[10:8] = 3'd0;
                        1:       c[10:8] = 3'd6;
                        default: c[10:8] = 3'd7;
                    endcase
                end
                8: begin
                    c[15:14] = 2'($urandom_range(0, 1));
                    sil      = 1'b1;
                end
                default: begin
                    if (n_dumps < 2) begin
                        n_dumps  = n_dumps + 1;
                        c[15:14] = 2'b10;
                        c[10:8]  = 3'($urandom_range(1, 5));
                        for (int i = 0; i < ENTRIES; i++) dump_src[i] = 8'($urandom);
                    end else begin
                        c[15:14] = 2'b00;
                    end
                end
            endcase
            run_xfer(c, r, sil, noisy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
